icache: RTL
===========

# icache

Direct-mapped, read-only instruction cache between the instruction fetcher and the memory controller inside the RV32I core. It serves fetch requests from a tag/data array. On a miss it issues one word fetch to the memory controller, fills the line, and answers the fetcher. There is a single outstanding request. A mispredict cancels the pending response but never aborts a memory transaction that has already started.

## Interface
- INDEX_WIDTH, 6: line index bits; 2^INDEX_WIDTH one-word lines.
- TAG_WIDTH, 16-INDEX_WIDTH: tag bits, taken from addr[17:INDEX_WIDTH+2].
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-low.
- rdy  in  1  global ready; when low, all state and outputs freeze.
- enable_from_if  in  1  fetch request; the fetcher holds it until ok_to_if.
- addr_from_if  in  32  fetch address; word aligned, bits [1:0] ignored.
- ok_to_if  out  1  one-cycle response pulse.
- ins_to_if  out  32  instruction word; valid while ok_to_if=1.
- enable_to_memctrl  out  1  word-fetch request to the memory controller.
- addr_to_memctrl  out  32  word-aligned fill address.
- ok_from_memctrl  in  1  fill-complete pulse.
- ins_from_memctrl  in  32  fill data; valid with ok_from_memctrl.
- mispredict  in  1  pipeline flush.
- hit_count  out  32  present only with ICACHE_STATS_EN.
- miss_count  out  32  present only with ICACHE_STATS_EN.

## Operation
- Storage per line: valid bit, tag, 32-bit data. Index = addr[INDEX_WIDTH+1:2].
- States: IDLE, FILL.
- IDLE accepts a request when all of the following hold in the same cycle: rdy=1, enable_from_if=1, ok_to_if=0, mispredict=0.
  - Hit (valid and tag match): register data, pulse ok_to_if next cycle, stay in IDLE.
  - Miss: latch the address with bits [1:0] forced to 00, clear the drop flag, set enable_to_memctrl=1, go to FILL.
- FILL holds enable_to_memctrl and addr_to_memctrl stable until ok_from_memctrl.
  - On ok_from_memctrl: write valid, tag and data into the line; drop enable_to_memctrl the next cycle; return to IDLE.
  - If the drop flag is clear, pulse ok_to_if the next cycle with ins_from_memctrl.
- mispredict in any state:
  - Forces ok_to_if=0 in the following cycle.
  - In FILL, sets the drop flag. The fill completes and the line is written, but no response is sent.
  - A request presented in the same cycle as mispredict is ignored.
- Lines are never invalidated except by reset. Code is read-only; no self-modifying-code support.
- ok_from_memctrl seen outside FILL is ignored.

## Timing
- Reset values: ok_to_if=0, ins_to_if=0, enable_to_memctrl=0, addr_to_memctrl=0, state=IDLE, drop flag=0, all valid bits=0, counters=0.
- Hit latency: request accepted in cycle N, ok_to_if=1 in cycle N+1.
- Hit throughput: no request is accepted in the ok cycle, so sustained rate is one hit every 2 cycles.
- Miss latency: enable_to_memctrl rises in cycle N+1. With ok_from_memctrl in cycle M, ok_to_if=1 in cycle M+1.
- ok_to_if is high for exactly one cycle per answered request.
- rdy low: nothing updates, including the array, counters and the drop flag. Inputs seen while rdy is low are ignored.
- Reset asserted mid-FILL: returns to IDLE on that edge and enable_to_memctrl falls. The memory controller is reset on the same edge.
- Same address re-requested immediately after a fill: hit.

## Configuration
- ICACHE_STATS_EN defined:
  - hit_count increments on each accepted hit; miss_count increments on each accepted miss, including later-dropped ones.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and clear on reset.
- ICACHE_STATS_EN undefined: counters and ports are absent; all other behaviour is identical.

## Test plan
- Cold miss:
  - Stimulus: after reset, request 0x00000000; memctrl returns 0x00000013 three cycles after its request.
  - Response: enable_to_memctrl=1 with addr 0x00000000, then ok_to_if with 0x00000013 one cycle after ok_from_memctrl.
- Hit after fill: re-request 0x00000000 -> ok_to_if in the next cycle with 0x00000013, and enable_to_memctrl stays 0.
- Conflict eviction (INDEX_WIDTH=6):
  - Stimulus: fill 0x00000004, then 0x00000104, then request 0x00000004.
  - Response: the third request misses, and memctrl sees addr 0x00000004 again.
- Mispredict during FILL:
  - Stimulus: miss on 0x00000040, pulse mispredict one cycle later.
  - Response: no ok_to_if. A later request to 0x00000040 hits with the filled data.
- rdy stall: hold rdy=0 for 5 cycles during a hit response -> ok_to_if stays asserted and frozen, then deasserts one cycle after rdy returns.
- Stats (ICACHE_STATS_EN): sequence miss, hit, hit, dropped miss -> hit_count=2, miss_count=2.

Source files
------------

// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache with one-word lines.
// Serves one outstanding fetch at a time; a miss issues a single word fetch
// to the memory controller, fills the line and then answers the fetcher.
// A mispredict suppresses the pending answer but lets a started fill finish.
// Optional feature macro: ICACHE_STATS_EN adds saturating hit/miss counters.
module icache #(
  parameter int INDEX_WIDTH = 6,
  parameter int TAG_WIDTH   = 16 - INDEX_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        enable_from_if,
  input  logic [31:0] addr_from_if,
  output logic        ok_to_if,
  output logic [31:0] ins_to_if,
  output logic        enable_to_memctrl,
  output logic [31:0] addr_to_memctrl,
  input  logic        ok_from_memctrl,
  input  logic [31:0] ins_from_memctrl,
  input  logic        mispredict
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int LINES = 1 << INDEX_WIDTH;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_ok;
  logic                   w_ok_nxt;
  logic [31:0]            r_ins;
  logic [31:0]            w_ins_nxt;
  logic                   r_mem_en;
  logic                   w_mem_en_nxt;
  logic [31:0]            r_mem_addr;
  logic [31:0]            w_mem_addr_nxt;
  logic                   r_drop;
  logic                   w_drop_nxt;

  logic [LINES-1:0]       r_valid;
  logic [TAG_WIDTH-1:0]   r_tag  [LINES];
  logic [31:0]            r_data [LINES];

  logic [INDEX_WIDTH-1:0] w_req_idx;
  logic [TAG_WIDTH-1:0]   w_req_tag;
  logic [INDEX_WIDTH-1:0] w_fill_idx;
  logic [TAG_WIDTH-1:0]   w_fill_tag;
  logic                   w_hit;
  logic                   w_accept;
  logic                   w_fill_done;
  logic                   w_unused_addr;

  assign w_req_idx   = addr_from_if[INDEX_WIDTH+1:2];
  assign w_req_tag   = addr_from_if[17:INDEX_WIDTH+2];
  assign w_fill_idx  = r_mem_addr[INDEX_WIDTH+1:2];
  assign w_fill_tag  = r_mem_addr[17:INDEX_WIDTH+2];
  // Byte offset inside the word is irrelevant for word fetches.
  assign w_unused_addr = ^addr_from_if[1:0];

  assign w_hit       = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
  // No new request in the answer cycle, and a flush cycle never starts one.
  assign w_accept    = (r_state == S_IDLE) && enable_from_if && !r_ok && !mispredict;
  assign w_fill_done = (r_state == S_FILL) && ok_from_memctrl;

  // Next-state and next-output decode; every target defaults to hold or idle.
  always_comb begin
    w_state_nxt    = r_state;
    w_ok_nxt       = 1'b0;
    w_ins_nxt      = r_ins;
    w_mem_en_nxt   = r_mem_en;
    w_mem_addr_nxt = r_mem_addr;
    w_drop_nxt     = r_drop;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_hit) begin
            w_ok_nxt  = 1'b1;
            w_ins_nxt = r_data[w_req_idx];
          end else begin
            w_mem_addr_nxt = {addr_from_if[31:2], 2'b00};
            w_mem_en_nxt   = 1'b1;
            w_drop_nxt     = 1'b0;
            w_state_nxt    = S_FILL;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FILL: begin
        // A flush during the fill only suppresses the answer.
        w_drop_nxt = r_drop | mispredict;
        if (w_fill_done) begin
          w_mem_en_nxt = 1'b0;
          w_state_nxt  = S_IDLE;
          if (!r_drop && !mispredict) begin
            w_ok_nxt  = 1'b1;
            w_ins_nxt = ins_from_memctrl;
          end else begin
            w_ok_nxt  = 1'b0;
          end
        end else begin
          w_state_nxt = S_FILL;
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_mem_en_nxt = 1'b0;
      end
    endcase
  end

  // Control/state registers: synchronous active-low reset, frozen while rdy is low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_ok       <= 1'b0;
      r_ins      <= 32'h0000_0000;
      r_mem_en   <= 1'b0;
      r_mem_addr <= 32'h0000_0000;
      r_drop     <= 1'b0;
    end else if (rdy) begin
      r_state    <= w_state_nxt;
      r_ok       <= w_ok_nxt;
      r_ins      <= w_ins_nxt;
      r_mem_en   <= w_mem_en_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_drop     <= w_drop_nxt;
    end
  end

  // Valid bits: cleared only by reset, set when a fill completes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= '0;
    end else if (rdy && w_fill_done) begin
      r_valid[w_fill_idx] <= 1'b1;
    end
  end

  // Tag/data array write on fill completion; contents need no reset.
  always_ff @(posedge clk) begin
    if (rst && rdy && w_fill_done) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= ins_from_memctrl;
    end
  end

  assign ok_to_if          = r_ok;
  assign ins_to_if         = r_ins;
  assign enable_to_memctrl = r_mem_en;
  assign addr_to_memctrl   = r_mem_addr;

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;
  logic        w_hit_inc;
  logic        w_miss_inc;

  assign w_hit_inc  = w_accept && w_hit;
  assign w_miss_inc = w_accept && !w_hit;

  // Saturating accepted-hit / accepted-miss counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hit_count  <= 32'h0000_0000;
      r_miss_count <= 32'h0000_0000;
    end else if (rdy) begin
      if (w_hit_inc && (r_hit_count != 32'hFFFF_FFFF)) begin
        r_hit_count <= r_hit_count + 32'd1;
      end
      if (w_miss_inc && (r_miss_count != 32'hFFFF_FFFF)) begin
        r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule
